// File: rtl/pcbfpga_cfg_loader.sv
`timescale 1ns/1ps
// pcbfpga_cfg_loader
//   Writer side of the pcbfpga configuration chain. Config bytes arrive from
//   the host on a valid/ready stream. They are serialised onto cfg_clk/cfg_data
//   one bit per cfg_clk period. When the whole chain has been shifted, the
//   block pulses cfg_latch so every primitive takes its new configuration at
//   the same time.
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a load (honoured only when idle or done)
//   abort      in   cancel the current load; no latch pulse follows
//   in_data    in   config byte
//   in_valid   in   in_data valid
//   in_ready   out  a byte is accepted this cycle (high only while fetching)
//   cfg_clk    out  chain shift clock; the chain samples on its rising edge
//   cfg_data   out  chain serial data
//   cfg_latch  out  chain parallel-load strobe, active high
//   busy       out  a load is in progress
//   done       out  sticky; set after a successful latch, cleared by start
//   bit_count  out  bits shifted so far in the current load
module pcbfpga_cfg_loader #(
  parameter int CHAIN_LEN = 256,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           cfg_clk,
  output logic                           cfg_data,
  output logic                           cfg_latch,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LEN_C    = CW'(CHAIN_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SETUP = 3'd2,
    S_HIGH  = 3'd3,
    S_LATCH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_r;
  logic [7:0]      shreg_r;
  logic [3:0]      bits_left_r;
  logic [DW-1:0]   div_r;

  // Moves the next bit to be sent into the lead position.
  function automatic logic [7:0] advance(input logic [7:0] b);
    if (MSB_FIRST) begin
      advance = {b[6:0], 1'b0};
    end else begin
      advance = {1'b0, b[7:1]};
    end
  endfunction

  // Bit that goes onto cfg_data next for a given shift register value.
  function automatic logic lead_bit(input logic [7:0] b);
    if (MSB_FIRST) begin
      lead_bit = b[7];
    end else begin
      lead_bit = b[0];
    end
  endfunction

  // Load sequencer; every output is a flop so cfg_clk/cfg_data/cfg_latch are glitch free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      shreg_r     <= 8'h00;
      bits_left_r <= 4'd0;
      div_r       <= '0;
      in_ready    <= 1'b0;
      cfg_clk     <= 1'b0;
      cfg_data    <= 1'b0;
      cfg_latch   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bit_count   <= '0;
    end else if (abort && (state_r != S_IDLE) && (state_r != S_DONE)) begin
      // bit_count is deliberately kept so the abort point is visible for debug
      state_r     <= S_IDLE;
      shreg_r     <= 8'h00;
      bits_left_r <= 4'd0;
      div_r       <= '0;
      in_ready    <= 1'b0;
      cfg_clk     <= 1'b0;
      cfg_data    <= 1'b0;
      cfg_latch   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          // abort arriving with start cancels the start
          if (start && !abort) begin
            bit_count <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            in_ready  <= 1'b1;
            state_r   <= S_FETCH;
          end else begin
            state_r   <= state_r;
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            shreg_r     <= in_data;
            bits_left_r <= 4'd8;
            cfg_data    <= lead_bit(in_data);
            in_ready    <= 1'b0;
            div_r       <= '0;
            state_r     <= S_SETUP;
          end else begin
            state_r     <= S_FETCH;
          end
        end
        S_SETUP: begin
          if (div_r == DIV_LAST) begin
            div_r   <= '0;
            cfg_clk <= 1'b1;
            state_r <= S_HIGH;
          end else begin
            div_r   <= div_r + DW'(1);
          end
        end
        S_HIGH: begin
          if (div_r == DIV_LAST) begin
            div_r       <= '0;
            cfg_clk     <= 1'b0;
            bit_count   <= bit_count + CW'(1);
            bits_left_r <= bits_left_r - 4'd1;
            shreg_r     <= advance(shreg_r);
            // chain full wins over byte boundaries: leftover bits are dropped
            if (bit_count + CW'(1) == LEN_C) begin
              cfg_latch <= 1'b1;
              state_r   <= S_LATCH;
            end else if (bits_left_r == 4'd1) begin
              in_ready  <= 1'b1;
              state_r   <= S_FETCH;
            end else begin
              cfg_data  <= lead_bit(advance(shreg_r));
              state_r   <= S_SETUP;
            end
          end else begin
            div_r       <= div_r + DW'(1);
          end
        end
        S_LATCH: begin
          if (div_r == DIV_LAST) begin
            div_r     <= '0;
            cfg_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= S_DONE;
          end else begin
            div_r     <= div_r + DW'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcbfpga_cfg_loader.sv
`timescale 1ns/1ps
// Bench for pcbfpga_cfg_loader. Two instances cover LSB-first/CLK_DIV=1 with a
// partial last byte (A) and MSB-first/CLK_DIV=3 (B). Each load is observed on
// the falling clock edge and compared against a bit stream computed directly
// from the bytes handed to the host interface.
module tb_pcbfpga_cfg_loader;

  localparam int LEN_A = 12;
  localparam int DIV_A = 1;
  localparam bit MSB_A = 1'b0;
  localparam int LEN_B = 16;
  localparam int DIV_B = 3;
  localparam bit MSB_B = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] start_v = 2'b00;
  logic [1:0] abort_v = 2'b00;
  logic [1:0] in_valid_v = 2'b00;
  logic [7:0] data_v [2];
  wire  [1:0] in_ready_v, cfg_clk_v, cfg_data_v, cfg_latch_v, busy_v, done_v;
  wire  [3:0] bc_a;
  wire  [4:0] bc_b;

  logic [7:0] load_bytes [4];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pcbfpga_cfg_loader #(.CHAIN_LEN(LEN_A), .CLK_DIV(DIV_A), .MSB_FIRST(MSB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .in_data(data_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .cfg_clk(cfg_clk_v[0]), .cfg_data(cfg_data_v[0]), .cfg_latch(cfg_latch_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .bit_count(bc_a));

  pcbfpga_cfg_loader #(.CHAIN_LEN(LEN_B), .CLK_DIV(DIV_B), .MSB_FIRST(MSB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .in_data(data_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .cfg_clk(cfg_clk_v[1]), .cfg_data(cfg_data_v[1]), .cfg_latch(cfg_latch_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .bit_count(bc_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_of(input int k);
    return (k == 0) ? LEN_A : LEN_B;
  endfunction

  function automatic int div_of(input int k);
    return (k == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic int bc_of(input int k);
    return (k == 0) ? int'(bc_a) : int'(bc_b);
  endfunction

  // Reference: chain bit i comes from byte i/8, taken MSB- or LSB-first.
  function automatic logic exp_bit(input int k, input int i);
    logic [7:0] b;
    int pos;
    b = load_bytes[i / 8];
    if (k == 0) pos = MSB_A ? 7 - (i % 8) : i % 8;
    else        pos = MSB_B ? 7 - (i % 8) : i % 8;
    return b[pos];
  endfunction

  // One load on instance k. abort_at >= 0 aborts once that many bits are done;
  // gap_byte >= 0 withholds that byte for 20 cycles; bump issues a start mid-load.
  task automatic run_load(input int k, input int abort_at, input int gap_byte, input bit bump);
    int len = len_of(k);
    int div = div_of(k);
    int nb = (len + 7) / 8;
    int sent = 0, rises = 0, falls = 0, cyc = 0;
    int hi_len = 0, lo_len = 0, latch_len = 0, latch_pulses = 0, gap = 0;
    logic prev_clk = 1'b0, prev_latch = 1'b0, held = 1'b0, latch_seen = 1'b0;
    bit finished = 1'b0;
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    check("start_busy", busy_v[k], 1);
    check("start_done_clear", done_v[k], 0);
    check("start_bitcnt", bc_of(k), 0);
    while (!finished && cyc < 3000) begin
      if (cfg_clk_v[k] && !prev_clk) begin
        check("bit", cfg_data_v[k], exp_bit(k, rises));
        if (rises % 8 != 0) check("low_phase", lo_len, div);
        else                check("low_phase_min", lo_len >= div, 1);
        held = cfg_data_v[k];
        rises++;
        hi_len = 0;
      end
      if (!cfg_clk_v[k] && prev_clk) begin
        check("high_phase", hi_len, div);
        falls++;
        lo_len = 0;
      end
      if (cfg_clk_v[k]) begin
        hi_len++;
        check("data_hold", cfg_data_v[k], held);
      end else begin
        lo_len++;
      end
      if (cfg_latch_v[k]) begin
        latch_len++;
        check("latch_after_chain", falls, len);
      end
      if (!cfg_latch_v[k] && prev_latch) begin
        latch_pulses++;
        check("latch_width", latch_len, div);
      end
      check("bitcnt", bc_of(k), falls);
      if (in_ready_v[k]) begin
        check("ready_no_extra_byte", sent < nb, 1);
        check("ready_clk_low", cfg_clk_v[k], 0);
      end
      if (done_v[k]) begin
        finished = 1'b1;
      end else if (abort_at >= 0 && falls == abort_at) begin
        abort_v[k] = 1'b1;
        in_valid_v[k] = 1'b0;
        @(negedge clk);
        abort_v[k] = 1'b0;
        check("abort_busy", busy_v[k], 0);
        check("abort_done", done_v[k], 0);
        check("abort_clk", cfg_clk_v[k], 0);
        check("abort_ready", in_ready_v[k], 0);
        check("abort_bitcnt_held", bc_of(k), abort_at);
        for (int c = 0; c < 12; c++) begin
          latch_seen |= cfg_latch_v[k];
          @(negedge clk);
        end
        check("abort_no_latch", latch_seen, 0);
        return;
      end else begin
        if (gap_byte == sent && in_ready_v[k] && gap < 20) begin
          in_valid_v[k] = 1'b0;
          gap++;
        end else begin
          in_valid_v[k] = (sent < nb) && ($urandom_range(0, 3) != 0);
        end
        if (sent < nb) data_v[k] = load_bytes[sent];
        if (in_valid_v[k] && in_ready_v[k]) sent++;
        start_v[k] = (bump && falls == 3) ? 1'b1 : 1'b0;
        prev_clk = cfg_clk_v[k];
        prev_latch = cfg_latch_v[k];
        cyc++;
        @(negedge clk);
      end
    end
    in_valid_v[k] = 1'b0;
    start_v[k] = 1'b0;
    check("load_finished", finished, 1);
    check("done_busy", busy_v[k], 0);
    check("done_ready", in_ready_v[k], 0);
    check("done_bitcnt", bc_of(k), len);
    check("done_rises", rises, len);
    check("done_latch_pulses", latch_pulses, 1);
  endtask

  initial begin
    data_v[0] = 8'h00;
    data_v[1] = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready_v, cfg_clk_v, cfg_data_v, cfg_latch_v, busy_v, done_v}, 0);
    check("reset_bitcnt", {bc_a, bc_b}, 0);
    rst_n = 1'b1;

    // Abort together with start while idle: start must be ignored.
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    check("abort_beats_start", {busy_v[0], in_ready_v[0]}, 0);

    // MSB-first 0xA5 then 0x3C with a 20-cycle stall before the second byte.
    load_bytes[0] = 8'hA5; load_bytes[1] = 8'h3C;
    run_load(1, -1, 1, 1'b1);
    // LSB-first, 12-bit chain: 0x3C, 0xFF -> second byte half discarded.
    load_bytes[0] = 8'h3C; load_bytes[1] = 8'hFF;
    run_load(0, -1, -1, 1'b0);
    // Abort after 5 bits, then a complete load.
    load_bytes[0] = 8'hC3; load_bytes[1] = 8'h81;
    run_load(1, 5, -1, 1'b0);
    run_load(1, -1, 0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      int k;
      int ab;
      k = int'($urandom_range(0, 1));
      for (int b = 0; b < 4; b++) load_bytes[b] = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len_of(k) - 1)) : -1;
      run_load(k, ab, int'($urandom_range(0, 2)) - 1, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while cfg_clk is high: outputs clear at once, no latch.
    begin
      int w = 0;
      logic latch_seen = 1'b0;
      load_bytes[0] = 8'h96;
      @(negedge clk);
      start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      data_v[1] = load_bytes[0];
      in_valid_v[1] = 1'b1;
      while (!cfg_clk_v[1] && w < 200) begin
        @(negedge clk);
        w++;
      end
      check("reach_high_phase", cfg_clk_v[1], 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {in_ready_v[1], cfg_clk_v[1], cfg_data_v[1],
                                    cfg_latch_v[1], busy_v[1], done_v[1]}, 0);
      check("async_reset_bitcnt", bc_b, 0);
      in_valid_v[1] = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (c == 3) rst_n = 1'b1;
        @(negedge clk);
        latch_seen |= cfg_latch_v[1];
      end
      check("reset_no_latch", latch_seen, 0);
      check("reset_idle", {busy_v[1], done_v[1]}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
